// File: rtl/bfp_pkg.sv
// rtl/bfp_pkg.sv - shared types and the bit-width to shift mapping for BFP tracking
package bfp_pkg;

  localparam int FFT_DW_DEF = 16;
  localparam int BW_W_DEF   = 5;
  localparam int EXP_W_DEF  = 8;

  typedef logic        [BW_W_DEF-1:0] bw_t;
  typedef logic signed [EXP_W_DEF-1:0] exp_t;
  typedef logic signed [BW_W_DEF:0]   shift_t;

  // Headroom target is one guard bit below the sign: an empty stage needs no scaling.
  function automatic int bw_to_shift(input int bw, input int fft_dw);
    return (bw == 0) ? 0 : (fft_dw - 2) - bw;
  endfunction

endpackage

// File: rtl/bfp_sign_bitwidth.sv
// rtl/bfp_sign_bitwidth.sv - significant bit width of a signed sample (leading sign bits removed)
module bfp_sign_bitwidth #(
  parameter int FFT_DW = 16,
  parameter int BW_W   = 5
) (
  input  logic [FFT_DW-1:0] value,
  output logic [BW_W-1:0]   bw
);

  logic [FFT_DW-1:0] mag;

  // Folding negative values onto their complement makes -1 and 0 both width 0.
  always_comb begin
    mag = value ^ {FFT_DW{value[FFT_DW-1]}};
    bw  = '0;
    for (int i = 0; i < FFT_DW - 1; i++) begin
      if (mag[i]) bw = BW_W'(i + 1);
    end
  end

endmodule

// File: rtl/bfp_exponent_tracker.sv
// rtl/bfp_exponent_tracker.sv - per-frame running max bit width, stage shift and BFP exponent
module bfp_exponent_tracker
  import bfp_pkg::*;
#(
  parameter int FFT_DW     = 16,
  parameter int BW_W       = 5,
  parameter int EXP_W      = 8,
  parameter int NUM_STAGES = 11,
  parameter int FIXED_EXP  = -6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic                     sample_valid,
  input  logic signed [FFT_DW-1:0] sample_re,
  input  logic signed [FFT_DW-1:0] sample_im,
  input  logic                     stage_done,
  input  logic                     mode_adaptive,
  output logic [BW_W-1:0]          stage_bw,
  output logic                     stage_bw_valid,
  output logic signed [BW_W:0]     shift_amt,
  output logic [3:0]               stage_idx,
  output logic                     frame_done,
  output logic signed [EXP_W-1:0]  bfp_exponent,
  output logic                     exp_sat,
  output logic                     seq_err
);

  localparam int SW = BW_W + 1;
  localparam int XW = ((EXP_W > SW) ? EXP_W : SW) + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 <<< (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MIN = -EXP_MAX - XW'(1);

  logic [BW_W-1:0]        bw_re, bw_im, bw_samp, run_max, m_comb;
  logic signed [SW-1:0]   shift_next;
  logic signed [XW-1:0]   exp_sum;
  logic signed [EXP_W-1:0] exp_next;
  logic                   sat_next;
  logic                   mode_q;

  bfp_sign_bitwidth #(.FFT_DW(FFT_DW), .BW_W(BW_W)) u_bw_re (.value(sample_re), .bw(bw_re));
  bfp_sign_bitwidth #(.FFT_DW(FFT_DW), .BW_W(BW_W)) u_bw_im (.value(sample_im), .bw(bw_im));

  always_comb begin
    bw_samp    = (bw_re > bw_im) ? bw_re : bw_im;
    m_comb     = (sample_valid && bw_samp > run_max) ? bw_samp : run_max;
    shift_next = SW'(bw_to_shift(int'(m_comb), FFT_DW));
    // Stage 0 restarts accumulation so a stale exponent never leaks into a new frame.
    exp_sum    = ((stage_idx == 4'd0) ? XW'(0) : XW'(bfp_exponent)) - XW'(shift_next);
    sat_next   = 1'b0;
    if (exp_sum > EXP_MAX) begin
      exp_next = EXP_W'(EXP_MAX);
      sat_next = 1'b1;
    end else if (exp_sum < EXP_MIN) begin
      exp_next = EXP_W'(EXP_MIN);
      sat_next = 1'b1;
    end else begin
      exp_next = EXP_W'(exp_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_bw       <= '0;
      stage_bw_valid <= 1'b0;
      shift_amt      <= '0;
      stage_idx      <= '0;
      frame_done     <= 1'b0;
      bfp_exponent   <= '0;
      exp_sat        <= 1'b0;
      seq_err        <= 1'b0;
      run_max        <= '0;
      mode_q         <= 1'b1;
    end else begin
      stage_bw_valid <= 1'b0;
      frame_done     <= 1'b0;
      if (frame_start) begin
        run_max      <= '0;
        stage_idx    <= '0;
        bfp_exponent <= mode_adaptive ? '0 : EXP_W'(FIXED_EXP);
        exp_sat      <= 1'b0;
        seq_err      <= 1'b0;
        mode_q       <= mode_adaptive;
      end else if (stage_done && stage_idx == 4'(NUM_STAGES)) begin
        seq_err <= 1'b1;
        if (sample_valid) run_max <= m_comb;
      end else if (stage_done) begin
        stage_bw       <= m_comb;
        shift_amt      <= shift_next;
        stage_bw_valid <= 1'b1;
        run_max        <= '0;
        stage_idx      <= stage_idx + 4'd1;
        frame_done     <= (stage_idx == 4'(NUM_STAGES - 1));
        if (mode_q) begin
          bfp_exponent <= exp_next;
          if (sat_next) exp_sat <= 1'b1;
        end else begin
          bfp_exponent <= EXP_W'(FIXED_EXP);
        end
      end else if (sample_valid) begin
        run_max <= m_comb;
      end
    end
  end

endmodule

// File: tb/tb_bfp_exponent_tracker.sv
// tb/tb_bfp_exponent_tracker.sv - directed self-checking bench for bfp_exponent_tracker
module tb_bfp_exponent_tracker;

  logic clk = 1'b0;
  logic reset, frame_start, sample_valid, stage_done, mode_adaptive;
  logic signed [15:0] sample_re, sample_im;

  logic [4:0]        stage_bw, stage_bw4;
  logic              stage_bw_valid, stage_bw_valid4;
  logic signed [5:0] shift_amt, shift_amt4;
  logic [3:0]        stage_idx, stage_idx4;
  logic              frame_done, frame_done4;
  logic signed [7:0] bfp_exponent;
  logic signed [3:0] bfp_exponent4;
  logic              exp_sat, exp_sat4, seq_err, seq_err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bfp_exponent_tracker dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sample_valid(sample_valid),
    .sample_re(sample_re), .sample_im(sample_im), .stage_done(stage_done),
    .mode_adaptive(mode_adaptive), .stage_bw(stage_bw), .stage_bw_valid(stage_bw_valid),
    .shift_amt(shift_amt), .stage_idx(stage_idx), .frame_done(frame_done),
    .bfp_exponent(bfp_exponent), .exp_sat(exp_sat), .seq_err(seq_err)
  );

  bfp_exponent_tracker #(.EXP_W(4)) dut4 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sample_valid(sample_valid),
    .sample_re(sample_re), .sample_im(sample_im), .stage_done(stage_done),
    .mode_adaptive(mode_adaptive), .stage_bw(stage_bw4), .stage_bw_valid(stage_bw_valid4),
    .shift_amt(shift_amt4), .stage_idx(stage_idx4), .frame_done(frame_done4),
    .bfp_exponent(bfp_exponent4), .exp_sat(exp_sat4), .seq_err(seq_err4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sample(input logic signed [15:0] re, input logic signed [15:0] im, input logic done);
    sample_valid = 1'b1;
    sample_re    = re;
    sample_im    = im;
    stage_done   = done;
    tick();
    sample_valid = 1'b0;
    stage_done   = 1'b0;
  endtask

  task automatic pulse_done();
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
  endtask

  task automatic start_frame(input logic adaptive);
    frame_start   = 1'b1;
    mode_adaptive = adaptive;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic check_stage(input string tag, input int bw, input int sh, input int ex, input int idx);
    check({tag, "_bw"}, int'(stage_bw), bw);
    check({tag, "_shift"}, int'(shift_amt), sh);
    check({tag, "_exp"}, int'(bfp_exponent), ex);
    check({tag, "_valid"}, int'(stage_bw_valid), 1);
    check({tag, "_idx"}, int'(stage_idx), idx);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; sample_valid = 1'b0; stage_done = 1'b0;
    mode_adaptive = 1'b1; sample_re = '0; sample_im = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_bw", int'(stage_bw), 0);
    check("rst_valid", int'(stage_bw_valid), 0);
    check("rst_shift", int'(shift_amt), 0);
    check("rst_idx", int'(stage_idx), 0);
    check("rst_exp", int'(bfp_exponent), 0);
    check("rst_flags", int'({frame_done, exp_sat, seq_err}), 0);

    // Stage 0: bw(0x0100)=9, bw(-3)=2
    start_frame(1'b1);
    drive_sample(16'sh0100, -16'sd3, 1'b0);
    pulse_done();
    check_stage("s0", 9, 5, -5, 1);
    tick();
    check("s0_valid_clear", int'(stage_bw_valid), 0);

    // Stage 1: full-scale extremes
    drive_sample(16'sh7FFF, 16'sh0000, 1'b0);
    drive_sample(-16'sd1, 16'sh8000, 1'b0);
    pulse_done();
    check_stage("s1", 15, -1, -4, 2);

    // Stage 2: only zero / -1 samples
    drive_sample(16'sh0000, -16'sd1, 1'b0);
    pulse_done();
    check_stage("s2", 0, 0, -4, 3);

    // Stage 3: bw 7 then bw 12 coincident with stage_done
    drive_sample(16'sh0040, 16'sh0000, 1'b0);
    drive_sample(16'sh0800, 16'sh0000, 1'b1);
    check_stage("s3", 12, 2, -6, 4);

    for (int s = 4; s < 10; s++) pulse_done();
    check("s9_idx", int'(stage_idx), 10);
    check("s9_no_frame_done", int'(frame_done), 0);
    pulse_done();
    check("s10_frame_done", int'(frame_done), 1);
    check("s10_idx", int'(stage_idx), 11);
    tick();
    check("frame_done_clear", int'(frame_done), 0);
    pulse_done();
    check("extra_seq_err", int'(seq_err), 1);
    check("extra_no_valid", int'(stage_bw_valid), 0);
    check("extra_idx", int'(stage_idx), 11);

    // frame_start beats a coincident stage_done
    stage_done = 1'b1;
    start_frame(1'b1);
    stage_done = 1'b0;
    check("fs_win_idx", int'(stage_idx), 0);
    check("fs_win_valid", int'(stage_bw_valid), 0);
    check("fs_win_seq", int'(seq_err), 0);
    check("fs_hold_bw", int'(stage_bw), 0);

    // Fixed mode latched at frame_start; mid-frame toggle ignored
    start_frame(1'b0);
    check("fix_exp_start", int'(bfp_exponent), -6);
    mode_adaptive = 1'b1;
    drive_sample(16'sh0100, 16'sh0000, 1'b0);
    pulse_done();
    check("fix_shift", int'(shift_amt), 5);
    check("fix_exp", int'(bfp_exponent), -6);

    // Abort mid-frame: no frame_done after restart
    start_frame(1'b1);
    check("abort_idx", int'(stage_idx), 0);
    check("abort_no_frame_done", int'(frame_done), 0);

    // bw=1 stages: shift 13 each; 4-bit exponent clamps at -8
    for (int s = 0; s < 3; s++) drive_sample(16'sh0001, 16'sh0000, 1'b1);
    check("sat_shift", int'(shift_amt4), 13);
    check("sat_exp4", int'(bfp_exponent4), -8);
    check("sat_flag4", int'(exp_sat4), 1);
    check("sat_exp8", int'(bfp_exponent), -39);
    check("sat_flag8", int'(exp_sat), 0);
    tick();
    check("sat_sticky", int'(exp_sat4), 1);
    start_frame(1'b1);
    check("sat_cleared", int'(exp_sat4), 0);
    check("sat_exp_cleared", int'(bfp_exponent4), 0);

    // Reset mid-operation
    drive_sample(16'sh0100, 16'sh0000, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_idx", int'(stage_idx), 0);
    check("mid_rst_bw", int'(stage_bw), 0);
    check("mid_rst_exp", int'(bfp_exponent), 0);
    pulse_done();
    check("mid_rst_runmax", int'(stage_bw), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
